// File: rtl/control_sequencer.sv
// Hardwired control sequencer: fetch (T0-T2), decode, and three-register ALU execute (T3-T5).
// Outputs are decoded purely from registered state, so they only move on a Clock edge or Clear.
module control_sequencer #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             Clock,
    input  logic             Clear,
    input  logic             Run,
    input  logic [31:0]      IR,
    input  logic             MemRdy,
    output logic [15:0]      Rin,
    output logic [15:0]      Rout,
    output logic             PCout,
    output logic             PCin,
    output logic             MARin,
    output logic             MDRin,
    output logic             MDRout,
    output logic             IRin,
    output logic             Yin,
    output logic             ZLowin,
    output logic             ZHighin,
    output logic             ZLowout,
    output logic             IncPC,
    output logic             Read,
    output logic [4:0]       OP,
    output logic             Busy,
    output logic             Halted,
    output logic             Fault,
    output logic [CNT_W-1:0] InstrCount
);

    localparam int unsigned WaitW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WaitW-1:0] WaitLast = WaitW'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        StIdle, StT0, StT1, StT1w, StT2, StDec, StT3, StT4, StT5, StHalt, StFault
    } state_e;

    state_e           state_q, state_d;
    logic [WaitW-1:0] wait_q, wait_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [4:0]       dec_op_q, dec_op_d;
    logic [4:0]       op_q, op_d;
    logic [3:0]       ra_q, ra_d, rb_q, rb_d, rc_q, rc_d;

    // Only opcode and register fields are used by this unit.
    logic unused_ir;
    assign unused_ir = ^IR[14:0];

    // State and sequencing registers; Clear returns everything to IDLE with zeroed outputs.
    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            state_q  <= StIdle;
            wait_q   <= '0;
            count_q  <= '0;
            dec_op_q <= '0;
            op_q     <= '0;
            ra_q     <= '0;
            rb_q     <= '0;
            rc_q     <= '0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            count_q  <= count_d;
            dec_op_q <= dec_op_d;
            op_q     <= op_d;
            ra_q     <= ra_d;
            rb_q     <= rb_d;
            rc_q     <= rc_d;
        end
    end

    // Next-state, memory wait timeout, opcode decode and retire counting.
    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        count_d  = count_q;
        dec_op_d = dec_op_q;
        op_d     = op_q;
        ra_d     = ra_q;
        rb_d     = rb_q;
        rc_d     = rc_q;
        unique case (state_q)
            StIdle: if (Run) state_d = StT0;
            StT0:   state_d = StT1;
            StT1: begin
                state_d = StT1w;
                wait_d  = '0;
            end
            StT1w: begin
                if (MemRdy) begin
                    state_d = StT2;
                end else if (wait_q == WaitLast) begin
                    state_d = StFault;
                end else begin
                    wait_d = wait_q + WaitW'(1);
                end
            end
            StT2: state_d = StDec;
            StDec: begin
                // Fields are captured here so later IR changes cannot disturb T3-T5.
                ra_d    = IR[26:23];
                rb_d    = IR[22:19];
                rc_d    = IR[18:15];
                state_d = StT3;
                case (IR[31:27])
                    5'b00011: dec_op_d = 5'b00100;
                    5'b00100: dec_op_d = 5'b00101;
                    5'b00101: dec_op_d = 5'b00110;
                    5'b00110: dec_op_d = 5'b00111;
                    5'b11011: state_d  = StHalt;
                    default:  state_d  = StFault;
                endcase
            end
            StT3: begin
                state_d = StT4;
                op_d    = dec_op_q;  // OP becomes visible in T4 and holds until reloaded
            end
            StT4: state_d = StT5;
            StT5: begin
                count_d = count_q + CNT_W'(1);
                state_d = Run ? StT0 : StIdle;
            end
            StHalt:  state_d = StHalt;
            StFault: state_d = StFault;
            default: state_d = StIdle;
        endcase
    end

    // Moore output decode from the registered state and captured fields.
    always_comb begin
        Rin     = '0;
        Rout    = '0;
        PCout   = 1'b0;
        PCin    = 1'b0;
        MARin   = 1'b0;
        MDRin   = 1'b0;
        MDRout  = 1'b0;
        IRin    = 1'b0;
        Yin     = 1'b0;
        ZLowin  = 1'b0;
        ZHighin = 1'b0;
        ZLowout = 1'b0;
        IncPC   = 1'b0;
        Read    = 1'b0;
        Busy    = 1'b1;
        Halted  = 1'b0;
        Fault   = 1'b0;
        unique case (state_q)
            StIdle: Busy = 1'b0;
            StT0: begin
                PCout   = 1'b1;
                MARin   = 1'b1;
                IncPC   = 1'b1;
                ZLowin  = 1'b1;
                ZHighin = 1'b1;
            end
            StT1: begin
                ZLowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
            end
            StT1w: begin
                Read  = 1'b1;
                MDRin = 1'b1;
            end
            StT2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            StDec: ;
            StT3: begin
                Rout = 16'h0001 << rb_q;
                Yin  = 1'b1;
            end
            StT4: begin
                Rout   = 16'h0001 << rc_q;
                ZLowin = 1'b1;
            end
            StT5: begin
                ZLowout = 1'b1;
                Rin     = 16'h0001 << ra_q;
            end
            StHalt: begin
                Busy   = 1'b0;
                Halted = 1'b1;
            end
            StFault: begin
                Busy  = 1'b0;
                Fault = 1'b1;
            end
            default: Busy = 1'b0;
        endcase
    end

    assign OP         = op_q;
    assign InstrCount = count_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer with a tiny bus/register-file model driven by its controls.
module tb_control_sequencer;

    localparam int unsigned TIMEOUT = 16;
    localparam int unsigned CNT_W   = 16;

    localparam logic [31:0] ADD_IR  = 32'h18228000;  // R0 <= R4 + R5
    localparam logic [31:0] SUB_IR  = 32'h20AA0000;  // R1 <= R5 - R4
    localparam logic [31:0] HALT_IR = 32'hD8000000;
    localparam logic [31:0] ILL_IR  = 32'hF8000000;

    // {PCout,PCin,MARin,MDRin,MDRout,IRin,Yin,ZLowin,ZHighin,ZLowout,IncPC,Read} per step
    localparam logic [11:0] SEQ_CTL  [8] = '{12'hA1A, 12'h405, 12'h101, 12'h0C0,
                                             12'h000, 12'h020, 12'h010, 12'h004};
    localparam logic [15:0] ADD_ROUT [8] = '{16'h0, 16'h0, 16'h0, 16'h0,
                                             16'h0, 16'h0010, 16'h0020, 16'h0};
    localparam logic [15:0] ADD_RIN  [8] = '{16'h0, 16'h0, 16'h0, 16'h0,
                                             16'h0, 16'h0, 16'h0, 16'h0001};

    logic             Clock, Clear, Run, MemRdy;
    logic [31:0]      IR;
    logic [15:0]      Rin, Rout;
    logic             PCout, PCin, MARin, MDRin, MDRout, IRin, Yin, ZLowin, ZHighin;
    logic             ZLowout, IncPC, Read, Busy, Halted, Fault;
    logic [4:0]       OP;
    logic [CNT_W-1:0] InstrCount;
    logic [11:0]      ctl;

    int vectors;
    int miscompares;

    control_sequencer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .Clock(Clock), .Clear(Clear), .Run(Run), .IR(IR), .MemRdy(MemRdy),
        .Rin(Rin), .Rout(Rout), .PCout(PCout), .PCin(PCin), .MARin(MARin), .MDRin(MDRin),
        .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .ZLowin(ZLowin), .ZHighin(ZHighin),
        .ZLowout(ZLowout), .IncPC(IncPC), .Read(Read), .OP(OP), .Busy(Busy),
        .Halted(Halted), .Fault(Fault), .InstrCount(InstrCount)
    );

    assign ctl = {PCout, PCin, MARin, MDRin, MDRout, IRin, Yin, ZLowin, ZHighin,
                  ZLowout, IncPC, Read};

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Datapath model: registers, PC, Y and Z reacting to the sequencer's controls.
    logic [31:0] dp_regs [16];
    logic [31:0] dp_pc, dp_y, dp_z, bus;

    always_comb begin
        bus = '0;
        if (PCout) bus = bus | dp_pc;
        if (ZLowout) bus = bus | dp_z;
        for (int i = 0; i < 16; i++) if (Rout[i]) bus = bus | dp_regs[i];
    end

    always @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            for (int i = 0; i < 16; i++) dp_regs[i] <= '0;
            dp_regs[4] <= 32'h14;
            dp_regs[5] <= 32'h18;
            dp_pc <= '0;
            dp_y  <= '0;
            dp_z  <= '0;
        end else begin
            if (Yin) dp_y <= bus;
            if (PCin) dp_pc <= bus;
            if (ZLowin) begin
                if (IncPC) dp_z <= bus + 32'd1;
                else begin
                    case (OP)
                        5'b00100: dp_z <= dp_y + bus;
                        5'b00101: dp_z <= dp_y - bus;
                        5'b00110: dp_z <= dp_y & bus;
                        5'b00111: dp_z <= dp_y | bus;
                        default:  dp_z <= '0;
                    endcase
                end
            end
            for (int i = 0; i < 16; i++) if (Rin[i]) dp_regs[i] <= bus;
        end
    end

    task automatic do_reset();
        Clear  = 1'b0;
        Run    = 1'b0;
        MemRdy = 1'b0;
        IR     = '0;
        repeat (2) @(negedge Clock);
        Clear = 1'b1;
    endtask

    task automatic test_reset();
        Clear = 1'b0;
        #1;
        vectors++;
        if ({ctl, Rin, Rout, OP, Busy, Halted, Fault, InstrCount} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: ctl=%h Rin=%h Rout=%h OP=%b Busy=%b H=%b F=%b cnt=%0d, want all 0",
                     ctl, Rin, Rout, OP, Busy, Halted, Fault, InstrCount);
        end
        do_reset();
        repeat (3) @(negedge Clock);
        vectors++;
        if (Busy !== 1'b0 || ctl !== 12'h000 || InstrCount !== '0) begin
            miscompares++;
            $display("FAIL idle_no_run: Busy=%b ctl=%h cnt=%0d, want 0 000 0", Busy, ctl, InstrCount);
        end
    endtask

    task automatic test_add();
        do_reset();
        IR = ADD_IR; MemRdy = 1'b1; Run = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge Clock);
            vectors++;
            if (ctl !== SEQ_CTL[i] || Rout !== ADD_ROUT[i] || Rin !== ADD_RIN[i] || Busy !== 1'b1) begin
                miscompares++;
                $display("FAIL add_step%0d: ctl=%h Rout=%h Rin=%h Busy=%b, want %h %h %h 1",
                         i, ctl, Rout, Rin, Busy, SEQ_CTL[i], ADD_ROUT[i], ADD_RIN[i]);
            end
            if (i == 6) begin
                vectors++;
                if (OP !== 5'b00100) begin
                    miscompares++;
                    $display("FAIL add_op_t4: OP=%b, want 00100", OP);
                end
            end
            Run = 1'b0;  // dropping Run mid-instruction must not abort it
        end
        @(negedge Clock);
        vectors++;
        if (Busy !== 1'b0 || InstrCount !== 16'd1 || dp_regs[0] !== 32'h2C || OP !== 5'b00100) begin
            miscompares++;
            $display("FAIL add_result: Busy=%b cnt=%0d R0=%h OP=%b, want 0 1 2c 00100",
                     Busy, InstrCount, dp_regs[0], OP);
        end
    endtask

    task automatic test_mem_wait();
        int n;
        do_reset();
        IR = ADD_IR; MemRdy = 1'b0; Run = 1'b1;
        @(negedge Clock);
        Run = 1'b0;
        @(negedge Clock);
        for (int k = 0; k < 4; k++) begin
            @(negedge Clock);
            vectors++;
            if (ctl !== 12'h101) begin
                miscompares++;
                $display("FAIL wait_t1w%0d: ctl=%h, want 101", k, ctl);
            end
            if (k == 3) MemRdy = 1'b1;
        end
        @(negedge Clock);
        vectors++;
        if (ctl !== 12'h0C0) begin
            miscompares++;
            $display("FAIL wait_t2: ctl=%h, want 0c0", ctl);
        end
        n = 0;
        while (Busy === 1'b1 && n < 20) begin
            @(negedge Clock);
            n++;
        end
        vectors++;
        if (Busy !== 1'b0 || dp_regs[0] !== 32'h2C || InstrCount !== 16'd1) begin
            miscompares++;
            $display("FAIL wait_result: Busy=%b R0=%h cnt=%0d, want 0 2c 1", Busy, dp_regs[0], InstrCount);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        IR = ADD_IR; MemRdy = 1'b0; Run = 1'b1;
        @(negedge Clock);
        Run = 1'b0;
        @(negedge Clock);
        @(negedge Clock);
        for (int n = 1; n < TIMEOUT; n++) begin
            @(negedge Clock);
            vectors++;
            if (Fault !== 1'b0 || ctl !== 12'h101) begin
                miscompares++;
                $display("FAIL timeout_early%0d: Fault=%b ctl=%h, want 0 101", n, Fault, ctl);
            end
        end
        @(negedge Clock);
        vectors++;
        if (Fault !== 1'b1 || Busy !== 1'b0 || ctl !== 12'h000 || Rin !== '0 || Rout !== '0) begin
            miscompares++;
            $display("FAIL timeout_fault: Fault=%b Busy=%b ctl=%h Rin=%h Rout=%h, want 1 0 000 0 0",
                     Fault, Busy, ctl, Rin, Rout);
        end
        MemRdy = 1'b1; Run = 1'b1;
        repeat (3) @(negedge Clock);
        vectors++;
        if (Fault !== 1'b1 || ctl !== 12'h000 || Busy !== 1'b0) begin
            miscompares++;
            $display("FAIL fault_sticky: Fault=%b ctl=%h Busy=%b, want 1 000 0", Fault, ctl, Busy);
        end
    endtask

    task automatic test_halt_illegal();
        int n;
        int pulses;
        do_reset();
        IR = ADD_IR; MemRdy = 1'b1; Run = 1'b1;
        for (int i = 0; i < 8; i++) @(negedge Clock);
        IR = HALT_IR;
        n = 0; pulses = 0;
        while (Halted !== 1'b1 && n < 20) begin
            @(negedge Clock);
            n++;
            if (Rin !== '0) pulses++;
        end
        vectors++;
        if (n !== 6 || Halted !== 1'b1 || Busy !== 1'b0 || Fault !== 1'b0 || pulses !== 0
            || InstrCount !== 16'd1) begin
            miscompares++;
            $display("FAIL halt: cycles=%0d H=%b Busy=%b F=%b rin_pulses=%0d cnt=%0d, want 6 1 0 0 0 1",
                     n, Halted, Busy, Fault, pulses, InstrCount);
        end
        repeat (3) @(negedge Clock);
        vectors++;
        if (Halted !== 1'b1 || InstrCount !== 16'd1 || ctl !== 12'h000) begin
            miscompares++;
            $display("FAIL halt_sticky: H=%b cnt=%0d ctl=%h, want 1 1 000", Halted, InstrCount, ctl);
        end
        do_reset();
        IR = ILL_IR; MemRdy = 1'b1; Run = 1'b1;
        n = 0;
        while (Fault !== 1'b1 && n < 20) begin
            @(negedge Clock);
            n++;
        end
        vectors++;
        if (n !== 6 || Fault !== 1'b1 || Halted !== 1'b0 || InstrCount !== '0) begin
            miscompares++;
            $display("FAIL illegal: cycles=%0d F=%b H=%b cnt=%0d, want 6 1 0 0", n, Fault, Halted, InstrCount);
        end
    endtask

    task automatic test_reset_mid_op();
        int n;
        do_reset();
        IR = ADD_IR; MemRdy = 1'b1; Run = 1'b1;
        for (int i = 0; i < 15; i++) @(negedge Clock);
        vectors++;
        if (ctl !== 12'h010 || Rout !== 16'h0020 || InstrCount !== 16'd1) begin
            miscompares++;
            $display("FAIL midop_t4: ctl=%h Rout=%h cnt=%0d, want 010 0020 1", ctl, Rout, InstrCount);
        end
        #2 Clear = 1'b0;
        #1;
        vectors++;
        if ({ctl, Rin, Rout, OP, Busy, InstrCount} !== '0) begin
            miscompares++;
            $display("FAIL midop_clear: ctl=%h Rin=%h Rout=%h OP=%b Busy=%b cnt=%0d, want all 0",
                     ctl, Rin, Rout, OP, Busy, InstrCount);
        end
        Run = 1'b0;
        @(negedge Clock);
        Clear = 1'b1; Run = 1'b1;
        @(negedge Clock);
        vectors++;
        if (ctl !== 12'hA1A || Busy !== 1'b1) begin
            miscompares++;
            $display("FAIL midop_refetch: ctl=%h Busy=%b, want a1a 1", ctl, Busy);
        end
        Run = 1'b0;
        n = 0;
        while (Busy === 1'b1 && n < 20) begin
            @(negedge Clock);
            n++;
        end
        vectors++;
        if (Busy !== 1'b0 || InstrCount !== 16'd1 || dp_regs[0] !== 32'h2C) begin
            miscompares++;
            $display("FAIL midop_result: Busy=%b cnt=%0d R0=%h, want 0 1 2c", Busy, InstrCount, dp_regs[0]);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        IR = ADD_IR; MemRdy = 1'b1; Run = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge Clock);
            if (i == 7) IR = SUB_IR;
            if (i == 8) begin
                vectors++;
                if (ctl !== 12'hA1A || InstrCount !== 16'd1) begin
                    miscompares++;
                    $display("FAIL b2b_t0: ctl=%h cnt=%0d, want a1a 1", ctl, InstrCount);
                end
            end
            if (i == 14) begin
                vectors++;
                if (OP !== 5'b00101 || Rout !== 16'h0010 || ctl !== 12'h010) begin
                    miscompares++;
                    $display("FAIL b2b_sub_t4: OP=%b Rout=%h ctl=%h, want 00101 0010 010", OP, Rout, ctl);
                end
            end
            if (i == 15) begin
                vectors++;
                if (ctl !== 12'h004 || Rin !== 16'h0002) begin
                    miscompares++;
                    $display("FAIL b2b_sub_t5: ctl=%h Rin=%h, want 004 0002", ctl, Rin);
                end
                Run = 1'b0;
            end
        end
        @(negedge Clock);
        vectors++;
        if (Busy !== 1'b0 || InstrCount !== 16'd2 || dp_regs[1] !== 32'h4 || dp_regs[0] !== 32'h2C) begin
            miscompares++;
            $display("FAIL b2b_result: Busy=%b cnt=%0d R1=%h R0=%h, want 0 2 4 2c",
                     Busy, InstrCount, dp_regs[1], dp_regs[0]);
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        Clear = 1'b0; Run = 1'b0; MemRdy = 1'b0; IR = '0;
        test_reset();
        test_add();
        test_mem_wait();
        test_timeout();
        test_halt_illegal();
        test_reset_mid_op();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000, want finished");
        $fatal(1);
    end

endmodule
